// File: rtl/srg_mips_pkg.sv
// Shared MIPS datapath definitions: machine width, divider FSM states and
// the R-type funct codes that select the divider.
package srg_mips_pkg;

  localparam int unsigned MIPS_WIDTH = 32;
  localparam int unsigned MIPS_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is exactly right when the result is read back as unsigned.
  function automatic logic [MIPS_WIDTH-1:0] mag(input logic [MIPS_WIDTH-1:0] v,
                                                input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/srg_div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the
// (WIDTH+1)-bit shifted partial remainder and keep or restore it.
module srg_div_step
  import srg_mips_pkg::*;
#(
  parameter int unsigned WIDTH = MIPS_WIDTH
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // part_rem < 2*divisor, so a kept difference and a restored value both fit WIDTH bits
  always_comb begin
    diff     = part_rem - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    next_rem = q_bit ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];
  end

endmodule

// File: rtl/srg_seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient feeds LO, remainder
// feeds HI. One quotient bit per RUN cycle, sign correction in FIX.
module srg_seq_divider
  import srg_mips_pkg::*;
#(
  parameter int unsigned WIDTH = MIPS_WIDTH,
  parameter int unsigned CNT_W = MIPS_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             divisor_zero;
  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  assign divisor_zero = (divisor == '0);
  assign dvd_neg      = is_signed & dividend[WIDTH-1];
  assign dsr_neg      = is_signed & divisor[WIDTH-1];

  // dvd_q doubles as the dividend shift register and the quotient accumulator
  srg_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .part_rem (({rem_q, dvd_q[WIDTH-1]})),
    .divisor  (dsr_q),
    .next_rem (step_rem),
    .q_bit    (step_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dbz_q <= 1'b0;
            if (divisor_zero) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end else begin
              dvd_q   <= mag(dividend, dvd_neg);
              dsr_q   <= mag(divisor, dsr_neg);
              rem_q   <= '0;
              cnt_q   <= '0;
              neg_q_q <= dvd_neg ^ dsr_neg;
              neg_r_q <= dvd_neg;
            end
          end
        end
        RUN: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], step_qbit};
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          quotient_q  <= neg_q_q ? (~dvd_q + 1'b1) : dvd_q;
          remainder_q <= neg_r_q ? (~rem_q + 1'b1) : rem_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = (state_q == RUN) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_srg_seq_divider.sv
// Self-checking bench for srg_seq_divider: directed vector table, hand
// sequences for start-ignore and mid-run reset, and randomized operations.
module tb_srg_seq_divider;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  srg_seq_divider #(
    .WIDTH(32),
    .CNT_W(5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, output logic [W-1:0] q,
                                output logic [W-1:0] r, output logic dz);
    longint sa, sb;
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
      if (s) begin
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end
  endfunction

  // Called at the negedge right after the accepting edge, start already low.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz);
    int lat, bcnt;
    logic [W-1:0] prev_q;
    @(negedge clk);
    prev_q    = quotient;
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    if (!edz) chk({tag, " held_q"}, quotient, prev_q);
    wait_done(lat, bcnt);
    chk({tag, " latency"}, lat, edz ? 1 : W + 2);
    if (!edz) chk({tag, " busy_cycles"}, bcnt, W + 1);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " dbz"}, div_by_zero, edz);
    chk({tag, " busy_in_done"}, busy, 1'b0);
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 1'b0);
    chk({tag, " q_stable"}, quotient, eq);
  endtask

  initial begin
    logic [W-1:0] rq, rr, a, b;
    logic rdz, s;
    int lat, bcnt;

    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{32'hFFFFFFF9, 32'd2,        1'b0, 32'h7FFFFFFC, 32'd1,        1'b0};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[5]  = '{32'h12345678, 32'd0,        1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[6]  = '{32'h12345678, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[7]  = '{32'h80000000, 32'd1,        1'b1, 32'h80000000, 32'd0,        1'b0};
    vecs[8]  = '{32'd7,        32'hFFFFFFF9, 1'b1, 32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[9]  = '{32'd5,        32'd10,       1'b0, 32'd0,        32'd5,        1'b0};
    vecs[10] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,        32'hFFFFFFFF, 1'b0};
    vecs[11] = '{32'h80000000, 32'h80000000, 1'b0, 32'd1,        32'd0,        1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
             vecs[i].eq, vecs[i].er, vecs[i].edz);
    end

    // Start during RUN is dropped; start while done is high is dropped too.
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 32'd77; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("ignore latency", lat + 6, W + 2);
    chk("ignore quotient", quotient, 32'd333);
    chk("ignore remainder", remainder, 32'd1);
    start = 1'b1; dividend = 32'd77; divisor = 32'd5;
    @(negedge clk);
    chk("start_at_done busy", busy, 1'b0);
    chk("start_at_done done", done, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("after_done latency", lat, W + 2);
    chk("after_done quotient", quotient, 32'd15);
    chk("after_done remainder", remainder, 32'd2);
    @(negedge clk);

    // Asynchronous reset around iteration 10 aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000000; divisor = 32'd7; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", busy, 1'b0);
    chk("arst done", done, 1'b0);
    chk("arst quotient", quotient, 32'd0);
    chk("arst remainder", remainder, 32'd0);
    bcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) bcnt++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) bcnt++;
    end
    chk("arst no_done", bcnt, 0);
    run_op("post_reset", 32'd1000000, 32'd7, 1'b0, 32'd142857, 32'd1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
        3:       begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(a, b, s, rq, rr, rdz);
      run_op($sformatf("rnd%0d", i), a, b, s, rq, rr, rdz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
